arm_control_unit: RTL and testbench
===================================

# arm_control_unit

- Control unit for the ARM single-cycle processor.
- Decodes the current instruction word from the datapath and drives every datapath control input.
- Holds the architectural NZCV flag register and performs ARM condition-code evaluation.
- Sits beside the datapath in the processor top level: it consumes `Instr` and the ALU flags, and sources `PCSrc`, `RegSrc`, `ImmSrc`, `ALUSrc`, `ALUControl`, `MemWrite`, `MemtoReg` and `RegWrite`.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `Instr`, in, 32: current instruction from instruction memory.
- `ALUFlags`, in, 4: live ALU outputs {N,Z,C,V} for the current instruction.
- `PCSrc`, out, 1: select `Result` as the next PC.
- `RegSrc`, out, 2: [0] forces RA1=R15; [1] selects Rd as RA2.
- `ImmSrc`, out, 2: extender format. 00 = imm8 rotate, 01 = imm12, 10 = imm24<<2.
- `ALUSrc`, out, 1: SrcB select; 1 selects ExtImm.
- `ALUControl`, out, 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `MemWrite`, out, 1: data memory write enable.
- `MemtoReg`, out, 1: Result = ReadData.
- `RegWrite`, out, 1: register file write enable.
- `Flags`, out, 4: stored {N,Z,C,V}.
- `RetiredCnt`, out, CNT_W: instructions whose condition passed and that decoded legal.
- `SquashedCnt`, out, CNT_W: instructions whose condition failed.
- `IllegalCnt`, out, CNT_W: undecodable instructions.

## Operation
Field names: Cond = `Instr[31:28]`, Op = `Instr[27:26]`, Funct = `Instr[25:20]`, Rd = `Instr[15:12]`.

Main decode (RegSrc, ImmSrc, ALUSrc, MemtoReg, RegW, MemW, Branch, ALUOp):
- Op=00, Funct[5]=0 (DP register): 00, 00, 0, 0, 1, 0, 0, 1.
- Op=00, Funct[5]=1 (DP immediate): 00, 00, 1, 0, 1, 0, 0, 1.
- Op=01, Funct[0]=0 (STR): 10, 01, 1, 0, 0, 1, 0, 0.
- Op=01, Funct[0]=1 (LDR): 00, 01, 1, 1, 1, 0, 0, 0.
- Op=10 (B): 01, 10, 1, 0, 0, 0, 1, 0.
- Op=11: illegal. All write enables are 0 and PCSrc=0.

ALU decode:
- ALUOp=0 gives ADD.
- With ALUOp=1, cmd=`Funct[4:1]` maps as: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB with NoWrite=1).
- Any other cmd is illegal and behaves as the Op=11 case. ALUControl is 00 for illegal instructions.
- FlagW[1] (NZ) = S (`Funct[0]`) on DP instructions.
- FlagW[0] (CV) = S & (ADD|SUB|CMP).

PC and condition logic:
- PCS = Branch | (RegW & Rd==4'hF).
- CondEx uses the stored `Flags` with standard ARM semantics: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
- Cond=1111 evaluates false.

Gated outputs:
- PCSrc = PCS & CondEx.
- MemWrite = MemW & CondEx.
- RegWrite = RegW & CondEx & ~NoWrite.
- MemtoReg, RegSrc, ImmSrc, ALUSrc and ALUControl are ungated.

Flag register:
- NZ is loaded from `ALUFlags[3:2]` when FlagW[1] & CondEx.
- CV is loaded from `ALUFlags[1:0]` when FlagW[0] & CondEx.
- Otherwise the flags hold.

## Timing
- All decode outputs are combinational from `Instr` and `Flags`, with zero latency within the cycle.
- Flag updates become visible on `Flags` the cycle after the setting instruction. A conditional instruction always evaluates against the flags held before its own update.
- A flag-setting instruction whose condition fails does not modify the flags.
- Reset values: `Flags`=0000 and all counters 0.
- Because the flags reset to 0000, at reset the outputs are purely a decode of `Instr` with Z=0 (EQ false, NE true).
- Asserting `rst_n` low mid-run clears the state immediately, without waiting for `clk`. The first edge after deassertion uses cleared flags.
- Counters wrap from 2^CNT_W−1 to 0. Exactly one counter increments per cycle (outside reset):
  - illegal has priority over squashed;
  - squashed has priority over retired.

## Configuration
- `ARM_CTRL_PERF_CNT_EN` defined: the three counters are implemented as described.
- Not defined: no counter flops exist, and `RetiredCnt`, `SquashedCnt` and `IllegalCnt` are tied to 0. Ports remain present.

## Test plan
- ADD R1,R2,R3 (0xE0821003) → RegWrite=1, ALUControl=00, ALUSrc=0, RegSrc=00, PCSrc=0, MemWrite=0.
- SUBS R0,R0,#1 (0xE2500001) with ALUFlags=0110 → RegWrite=1, ALUControl=01, ALUSrc=1; `Flags`=0110 after the edge. Repeat with Cond=0000 and Flags Z=0 → Flags unchanged, SquashedCnt +1.
- CMP R0,R1 (0xE1500001) with ALUFlags=1000 → RegWrite=0, ALUControl=01, Flags=1000 next cycle.
- BEQ (0x0A000002): with Z=1 → PCSrc=1, ImmSrc=10, RegSrc=01, RetiredCnt +1. With Z=0 → PCSrc=0, SquashedCnt +1.
- LDR R15,[R1] (0xE591F000) → PCSrc=1, MemtoReg=1, RegWrite=1. STR R2,[R1,#4] (0xE5812004) → MemWrite=1, RegSrc=10, RegWrite=0.
- 0xEF000000 → all write enables 0 and IllegalCnt +1. Pulse `rst_n` low between clock edges → Flags and counters read 0 before the next `clk` edge.

Source files
------------

// File: rtl/arm_control_unit.sv
// ARM single-cycle control unit: instruction decode, NZCV flag register, condition evaluation.
// Optional performance counters are built only when ARM_CTRL_PERF_CNT_EN is defined.
module arm_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instr,
  input  logic [3:0]       ALUFlags,
  output logic             PCSrc,
  output logic [1:0]       RegSrc,
  output logic [1:0]       ImmSrc,
  output logic             ALUSrc,
  output logic [1:0]       ALUControl,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] RetiredCnt,
  output logic [CNT_W-1:0] SquashedCnt,
  output logic [CNT_W-1:0] IllegalCnt
);

  logic [3:0] r_flags;
  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_s;
  logic [1:0] w_regsrc, w_immsrc, w_aluctl, w_flagw;
  logic       w_alusrc, w_memtoreg, w_regw, w_memw, w_branch, w_nowrite;
  logic       w_ill, w_pcs, w_condex;
  logic       w_unused_bits;

  assign w_cond  = Instr[31:28];
  assign w_op    = Instr[27:26];
  assign w_funct = Instr[25:20];
  assign w_rd    = Instr[15:12];
  assign w_s     = w_funct[0];
  assign w_unused_bits = ^{Instr[19:16], Instr[11:0]};

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = ~z;
      4'h2:    cond_eval = c;
      4'h3:    cond_eval = ~c;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = ~n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = ~v;
      4'h8:    cond_eval = c & ~z;
      4'h9:    cond_eval = ~c | z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = ~z & (n == v);
      4'hD:    cond_eval = z | (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Main and ALU decode; an illegal encoding collapses every control to zero.
  always_comb begin
    w_regsrc   = 2'b00;
    w_immsrc   = 2'b00;
    w_alusrc   = 1'b0;
    w_memtoreg = 1'b0;
    w_regw     = 1'b0;
    w_memw     = 1'b0;
    w_branch   = 1'b0;
    w_aluctl   = 2'b00;
    w_nowrite  = 1'b0;
    w_flagw    = 2'b00;
    w_ill      = 1'b0;
    case (w_op)
      2'b00: begin
        w_regw   = 1'b1;
        w_alusrc = w_funct[5];
        case (w_funct[4:1])
          4'b0100: begin w_aluctl = 2'b00; w_flagw = {w_s, w_s}; end
          4'b0010: begin w_aluctl = 2'b01; w_flagw = {w_s, w_s}; end
          4'b0000: begin w_aluctl = 2'b10; w_flagw = {w_s, 1'b0}; end
          4'b1100: begin w_aluctl = 2'b11; w_flagw = {w_s, 1'b0}; end
          4'b1010: begin w_aluctl = 2'b01; w_flagw = {w_s, w_s}; w_nowrite = 1'b1; end
          default: w_ill = 1'b1;
        endcase
      end
      2'b01: begin
        w_immsrc = 2'b01;
        w_alusrc = 1'b1;
        if (w_funct[0]) begin
          w_memtoreg = 1'b1;
          w_regw     = 1'b1;
        end else begin
          w_regsrc = 2'b10;
          w_memw   = 1'b1;
        end
      end
      2'b10: begin
        w_regsrc = 2'b01;
        w_immsrc = 2'b10;
        w_alusrc = 1'b1;
        w_branch = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_regsrc   = 2'b00;
      w_immsrc   = 2'b00;
      w_alusrc   = 1'b0;
      w_memtoreg = 1'b0;
      w_regw     = 1'b0;
      w_memw     = 1'b0;
      w_branch   = 1'b0;
      w_aluctl   = 2'b00;
      w_nowrite  = 1'b0;
      w_flagw    = 2'b00;
    end
  end

  assign w_condex = cond_eval(w_cond, r_flags);
  assign w_pcs    = w_branch | (w_regw & (w_rd == 4'hF));

  assign PCSrc      = w_pcs & w_condex;
  assign MemWrite   = w_memw & w_condex;
  assign RegWrite   = w_regw & w_condex & ~w_nowrite;
  assign MemtoReg   = w_memtoreg;
  assign RegSrc     = w_regsrc;
  assign ImmSrc     = w_immsrc;
  assign ALUSrc     = w_alusrc;
  assign ALUControl = w_aluctl;
  assign Flags      = r_flags;

  // NZ and CV load independently, and only when the instruction's condition passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else begin
      if (w_flagw[1] & w_condex) r_flags[3:2] <= ALUFlags[3:2];
      if (w_flagw[0] & w_condex) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef ARM_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_retired, r_squashed, r_illegal;

  // Exactly one counter advances per cycle: illegal beats squashed beats retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired  <= '0;
      r_squashed <= '0;
      r_illegal  <= '0;
    end else if (w_ill) begin
      r_illegal  <= r_illegal + CNT_W'(1);
    end else if (!w_condex) begin
      r_squashed <= r_squashed + CNT_W'(1);
    end else begin
      r_retired  <= r_retired + CNT_W'(1);
    end
  end

  assign RetiredCnt  = r_retired;
  assign SquashedCnt = r_squashed;
  assign IllegalCnt  = r_illegal;
`else
  assign RetiredCnt  = '0;
  assign SquashedCnt = '0;
  assign IllegalCnt  = '0;
`endif

endmodule

// File: tb/tb_arm_control_unit.sv
// Self-checking bench for arm_control_unit with a behavioural reference model.
module tb_arm_control_unit;
  localparam int CW = 4;
`ifdef ARM_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   Instr;
  logic [3:0]    ALUFlags;
  logic          PCSrc, ALUSrc, MemWrite, MemtoReg, RegWrite;
  logic [1:0]    RegSrc, ImmSrc, ALUControl;
  logic [3:0]    Flags;
  logic [CW-1:0] RetiredCnt, SquashedCnt, IllegalCnt;

  int checks = 0;
  int failures = 0;

  logic [3:0]    m_flags;
  logic [CW-1:0] m_ret, m_sq, m_ill;
  logic [31:0]   last_i;
  logic [3:0]    last_af;

  typedef struct packed {
    logic       pcsrc;
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       alusrc;
    logic [1:0] aluc;
    logic       memw;
    logic       mtr;
    logic       regw;
    logic       ill;
    logic       cond;
    logic [1:0] flagw;
  } exp_t;

  arm_control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCSrc(PCSrc), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
    .ALUControl(ALUControl), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .Flags(Flags), .RetiredCnt(RetiredCnt),
    .SquashedCnt(SquashedCnt), .IllegalCnt(IllegalCnt)
  );

  always #5 clk = ~clk;

  // Conditions come in complementary pairs: the low bit inverts the base test.
  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: return !cc[0];
    endcase
    return cc[0] ? !r : r;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [3:0] fl);
    exp_t e;
    int cmd;
    bit s, rdpc, regw, memw, br, nowr;
    e = '0;
    cmd = int'(ins[24:21]);
    s = ins[20];
    rdpc = (ins[15:12] == 4'd15);
    regw = 0; memw = 0; br = 0; nowr = 0;
    e.cond = cond_ok(ins[31:28], fl);
    if (ins[27:26] == 2'd0) begin
      if (cmd == 4) e.aluc = 2'd0;
      else if (cmd == 2) e.aluc = 2'd1;
      else if (cmd == 0) e.aluc = 2'd2;
      else if (cmd == 12) e.aluc = 2'd3;
      else if (cmd == 10) begin e.aluc = 2'd1; nowr = 1; end
      else e.ill = 1;
      if (!e.ill) begin
        regw = 1;
        e.alusrc = ins[25];
        e.flagw = {s, s && (cmd == 4 || cmd == 2 || cmd == 10)};
      end
    end else if (ins[27:26] == 2'd1) begin
      e.immsrc = 2'd1;
      e.alusrc = 1;
      if (s) begin e.mtr = 1; regw = 1; end
      else begin e.regsrc = 2'd2; memw = 1; end
    end else if (ins[27:26] == 2'd2) begin
      e.regsrc = 2'd1; e.immsrc = 2'd2; e.alusrc = 1; br = 1;
    end else begin
      e.ill = 1;
    end
    e.pcsrc = (br || (regw && rdpc)) && e.cond;
    e.memw  = memw && e.cond;
    e.regw  = regw && e.cond && !nowr;
    return e;
  endfunction

  task automatic mdl_step(input logic [31:0] ins, input logic [3:0] af);
    exp_t e;
    e = model(ins, m_flags);
    if (e.flagw[1] && e.cond) m_flags[3:2] = af[3:2];
    if (e.flagw[0] && e.cond) m_flags[1:0] = af[1:0];
    if (e.ill) m_ill = m_ill + 1'b1;
    else if (!e.cond) m_sq = m_sq + 1'b1;
    else m_ret = m_ret + 1'b1;
  endtask

  task automatic mdl_reset();
    m_flags = 4'd0; m_ret = '0; m_sq = '0; m_ill = '0;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [3:0] af);
    @(negedge clk);
    Instr = ins; ALUFlags = af; last_i = ins; last_af = af;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Instr = 32'h0A000002; ALUFlags = 4'hF;
    last_i = Instr; last_af = ALUFlags;
    mdl_reset();
    #2;
    checks++; if (Flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", Flags); end
    checks++; if ({RetiredCnt, SquashedCnt, IllegalCnt} !== '0) begin failures++; $display("FAIL reset_cnt got=%h/%h/%h exp=0", RetiredCnt, SquashedCnt, IllegalCnt); end
    checks++; if (PCSrc !== 1'b0) begin failures++; $display("FAIL reset_beq_pcsrc got=%b exp=0", PCSrc); end
    @(negedge clk); #1;
    checks++; if (Flags !== 4'h0) begin failures++; $display("FAIL reset_hold_flags got=%h exp=0", Flags); end
    rst_n = 1'b1;
    mdl_step(last_i, last_af);
  endtask

  task automatic test_dp();
    drive(32'hE0821003, 4'h0);
    checks++; if ({RegWrite, ALUControl, ALUSrc, RegSrc, PCSrc, MemWrite} !== 8'b1_00_0_00_0_0) begin failures++;
      $display("FAIL add_ctrl got=%b exp=10000000", {RegWrite, ALUControl, ALUSrc, RegSrc, PCSrc, MemWrite}); end
    mdl_step(last_i, last_af);
    drive(32'hE2500001, 4'b0110);
    checks++; if ({RegWrite, ALUControl, ALUSrc} !== 4'b1011) begin failures++;
      $display("FAIL subs_ctrl got=%b exp=1011", {RegWrite, ALUControl, ALUSrc}); end
    mdl_step(last_i, last_af);
    drive(32'hE1500001, 4'b1000);
    checks++; if (Flags !== 4'b0110) begin failures++; $display("FAIL subs_flags got=%b exp=0110", Flags); end
    checks++; if ({RegWrite, ALUControl} !== 3'b001) begin failures++; $display("FAIL cmp_ctrl got=%b exp=001", {RegWrite, ALUControl}); end
    mdl_step(last_i, last_af);
    drive(32'h02500001, 4'b0110);
    checks++; if (Flags !== 4'b1000) begin failures++; $display("FAIL cmp_flags got=%b exp=1000", Flags); end
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL subseq_squash_regw got=%b exp=0", RegWrite); end
    mdl_step(last_i, last_af);
    drive(32'hE2500001, 4'b0100);
    checks++; if (Flags !== 4'b1000) begin failures++; $display("FAIL squash_flags_hold got=%b exp=1000", Flags); end
    checks++; if (SquashedCnt !== (PERF ? m_sq : '0)) begin failures++; $display("FAIL squash_cnt got=%h exp=%h", SquashedCnt, PERF ? m_sq : '0); end
    mdl_step(last_i, last_af);
  endtask

  task automatic test_branch_mem();
    drive(32'h0A000002, 4'h0);
    checks++; if ({PCSrc, ImmSrc, RegSrc} !== 5'b1_10_01) begin failures++; $display("FAIL beq_taken got=%b exp=11001", {PCSrc, ImmSrc, RegSrc}); end
    mdl_step(last_i, last_af);
    drive(32'hE1500001, 4'b0000);
    checks++; if (RetiredCnt !== (PERF ? m_ret : '0)) begin failures++; $display("FAIL beq_retired got=%h exp=%h", RetiredCnt, PERF ? m_ret : '0); end
    mdl_step(last_i, last_af);
    drive(32'h0A000002, 4'h0);
    checks++; if (PCSrc !== 1'b0) begin failures++; $display("FAIL beq_not_taken got=%b exp=0", PCSrc); end
    mdl_step(last_i, last_af);
    drive(32'hE591F000, 4'h0);
    checks++; if (SquashedCnt !== (PERF ? m_sq : '0)) begin failures++; $display("FAIL beq_squashed got=%h exp=%h", SquashedCnt, PERF ? m_sq : '0); end
    checks++; if ({PCSrc, MemtoReg, RegWrite} !== 3'b111) begin failures++; $display("FAIL ldr_pc got=%b exp=111", {PCSrc, MemtoReg, RegWrite}); end
    mdl_step(last_i, last_af);
    drive(32'hE5812004, 4'h0);
    checks++; if ({MemWrite, RegSrc, RegWrite} !== 4'b1_10_0) begin failures++; $display("FAIL str_ctrl got=%b exp=1100", {MemWrite, RegSrc, RegWrite}); end
    mdl_step(last_i, last_af);
    drive(32'hEF000000, 4'hF);
    checks++; if ({PCSrc, MemWrite, RegWrite} !== 3'b000) begin failures++; $display("FAIL illegal_we got=%b exp=000", {PCSrc, MemWrite, RegWrite}); end
    mdl_step(last_i, last_af);
    drive(32'hE0821003, 4'h0);
    checks++; if (IllegalCnt !== (PERF ? m_ill : '0)) begin failures++; $display("FAIL illegal_cnt got=%h exp=%h", IllegalCnt, PERF ? m_ill : '0); end
    mdl_step(last_i, last_af);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [3:0]  af;
    logic [11:0] got, want;
    exp_t e;
    for (int k = 0; k < 400; k++) begin
      ins = $urandom;
      af  = 4'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        case ($urandom_range(5, 0))
          0: ins[24:21] = 4'd4;
          1: ins[24:21] = 4'd2;
          2: ins[24:21] = 4'd10;
          3: ins[24:21] = 4'd12;
          4: ins[24:21] = 4'd0;
          default: ins[15:12] = 4'hF;
        endcase
        ins[27:26] = 2'($urandom_range(2, 0));
      end
      if ($urandom_range(3, 0) == 0) ins[31:28] = 4'hE;
      drive(ins, af);
      e = model(ins, m_flags);
      if (e.ill) begin
        got  = {8'd0, PCSrc, MemWrite, RegWrite, |ALUControl};
        want = 12'd0;
      end else begin
        got  = {PCSrc, RegSrc, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, RegWrite, 1'b0};
        want = {e.pcsrc, e.regsrc, e.immsrc, e.alusrc, e.aluc, e.memw, e.mtr, e.regw, 1'b0};
      end
      checks++; if (got !== want) begin failures++; $display("FAIL rand_decode instr=%h flags=%b got=%h exp=%h", ins, m_flags, got, want); end
      checks++; if (Flags !== m_flags) begin failures++; $display("FAIL rand_flags instr=%h got=%b exp=%b", ins, Flags, m_flags); end
      checks++; if ({RetiredCnt, SquashedCnt, IllegalCnt} !== (PERF ? {m_ret, m_sq, m_ill} : '0)) begin failures++;
        $display("FAIL rand_cnt got=%h/%h/%h exp=%h/%h/%h", RetiredCnt, SquashedCnt, IllegalCnt, m_ret, m_sq, m_ill); end
      mdl_step(last_i, last_af);
    end
  endtask

  task automatic test_async_reset();
    drive(32'hE2500001, 4'b1111);
    mdl_step(last_i, last_af);
    @(negedge clk); #2;
    checks++; if (Flags !== m_flags) begin failures++; $display("FAIL pre_areset_flags got=%b exp=%b", Flags, m_flags); end
    rst_n = 1'b0;
    #1;
    checks++; if (Flags !== 4'h0) begin failures++; $display("FAIL areset_flags got=%b exp=0", Flags); end
    checks++; if ({RetiredCnt, SquashedCnt, IllegalCnt} !== '0) begin failures++; $display("FAIL areset_cnt got=%h/%h/%h exp=0", RetiredCnt, SquashedCnt, IllegalCnt); end
    #1;
    rst_n = 1'b1;
    mdl_reset();
    mdl_step(last_i, last_af);
    drive(32'h1A000002, 4'h0);
    checks++; if (Flags !== m_flags) begin failures++; $display("FAIL post_areset_flags got=%b exp=%b", Flags, m_flags); end
    checks++; if (PCSrc !== model(last_i, m_flags).pcsrc) begin failures++; $display("FAIL post_areset_bne got=%b exp=%b", PCSrc, model(last_i, m_flags).pcsrc); end
    checks++; if ({RetiredCnt, SquashedCnt, IllegalCnt} !== (PERF ? {m_ret, m_sq, m_ill} : '0)) begin failures++;
      $display("FAIL post_areset_cnt got=%h/%h/%h exp=%h/%h/%h", RetiredCnt, SquashedCnt, IllegalCnt, m_ret, m_sq, m_ill); end
    mdl_step(last_i, last_af);
  endtask

  initial begin
    test_reset();
    test_dp();
    test_branch_mem();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
